// File: rtl/arcade_video_timing_if.sv
// Raster timing bundle between the timing generator and the arcade video
// output stage. ce_pix is the only qualifier: beam position, blanking, sync
// and frame are valid whenever ce_pix is high and hold their value between
// pixel steps. There is no back-pressure; the consumer must accept every
// pixel. h_shift/v_shift flow from the consumer and are sampled by the
// generator only at the start of a frame.
interface arcade_video_timing_if #(
    parameter int HW = 9,
    parameter int VW = 9
) ();
    logic [3:0]    h_shift;
    logic [3:0]    v_shift;
    logic          ce_pix;
    logic          HBlank;
    logic          VBlank;
    logic          HSync;
    logic          VSync;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          frame;

    // Timing generator side.
    modport master (
        input  h_shift, v_shift,
        output ce_pix, HBlank, VBlank, HSync, VSync, hcnt, vcnt, frame
    );

    // Video output stage side.
    modport slave (
        output h_shift, v_shift,
        input  ce_pix, HBlank, VBlank, HSync, VSync, hcnt, vcnt, frame
    );
endinterface

// File: rtl/arcade_video_timing.sv
// Raster timing generator for arcade cores: pixel enable, blanking, sync,
// beam position and frame strobe. The signed sync position shift is latched
// at the start of each frame so the picture never tears mid-frame.
module arcade_video_timing #(
    parameter int CE_DIV   = 4,
    parameter int H_TOTAL  = 384,
    parameter int H_ACTIVE = 256,
    parameter int HS_START = 304,
    parameter int HS_END   = 336,
    parameter int V_TOTAL  = 264,
    parameter int V_ACTIVE = 224,
    parameter int VS_START = 240,
    parameter int VS_END   = 243,
    parameter int HW       = 9,
    parameter int VW       = 9
) (
    input  logic                   clk_video,
    input  logic                   reset,
    arcade_video_timing_if.master  vid
);

    // Parameter legality: sync pulses must stay inside the blanking region
    // with an 8-unit margin on each side so a shift of -8..+7 never wraps.
    if (CE_DIV < 1 || CE_DIV > 16) begin : g_bad_ce_div
        $error("arcade_video_timing: CE_DIV must be 1..16");
    end
    if (!(H_ACTIVE + 8 <= HS_START && HS_START < HS_END && HS_END <= H_TOTAL - 8)) begin : g_bad_h
        $error("arcade_video_timing: horizontal sync range illegal");
    end
    if (!(V_ACTIVE + 8 <= VS_START && VS_START < VS_END && VS_END <= V_TOTAL - 8)) begin : g_bad_v
        $error("arcade_video_timing: vertical sync range illegal");
    end
    if (HW < 4 || VW < 4 || H_TOTAL > (1 << HW) || V_TOTAL > (1 << VW)) begin : g_bad_width
        $error("arcade_video_timing: counter widths too small");
    end

    localparam int DW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CE_DIV - 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACTIVE_W = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACTIVE_W = VW'(V_ACTIVE);

    // Sync edges in HW+1 / VW+1 bit signed form so shifted compares never wrap.
    localparam logic signed [HW:0] HS_START_S = (HW+1)'(HS_START);
    localparam logic signed [HW:0] HS_END_S   = (HW+1)'(HS_END);
    localparam logic signed [VW:0] VS_START_S = (VW+1)'(VS_START);
    localparam logic signed [VW:0] VS_END_S   = (VW+1)'(VS_END);

    logic [DW-1:0] div_q;
    logic [HW-1:0] h_pos;
    logic [VW-1:0] v_pos;
    logic [3:0]    hs_q;
    logic [3:0]    vs_q;

    logic          step;
    logic          h_wrap;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          new_frame;
    logic [3:0]    hs_eff;
    logic [3:0]    vs_eff;
    logic signed [HW:0] h_s;
    logic signed [VW:0] v_s;
    logic signed [HW:0] hs_ext;
    logic signed [VW:0] vs_ext;
    logic          hsync_nxt;
    logic          vsync_nxt;

    assign step = (div_q == DIV_LAST);

    // Next beam position and the sync decisions for that position.
    always_comb begin
        h_wrap = (h_pos == H_LAST);
        h_nxt  = h_wrap ? '0 : h_pos + HW'(1);
        v_nxt  = v_pos;
        if (h_wrap) begin
            v_nxt = (v_pos == V_LAST) ? '0 : v_pos + VW'(1);
        end
        new_frame = (h_nxt == '0) && (v_nxt == '0);
        // The shift captured at (0,0) already applies to that pixel.
        hs_eff = new_frame ? vid.h_shift : hs_q;
        vs_eff = new_frame ? vid.v_shift : vs_q;
        hs_ext = $signed({{(HW-3){hs_eff[3]}}, hs_eff});
        vs_ext = $signed({{(VW-3){vs_eff[3]}}, vs_eff});
        h_s    = $signed({1'b0, h_nxt});
        v_s    = $signed({1'b0, v_nxt});
        hsync_nxt = (h_s >= HS_START_S + hs_ext) && (h_s < HS_END_S + hs_ext);
        vsync_nxt = (v_s >= VS_START_S + vs_ext) && (v_s < VS_END_S + vs_ext);
    end

    // Pixel divider, beam position, shift latch and registered timing outputs.
    always_ff @(posedge clk_video or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            h_pos      <= H_LAST;
            v_pos      <= V_LAST;
            hs_q       <= '0;
            vs_q       <= '0;
            vid.ce_pix <= 1'b0;
            vid.HBlank <= 1'b0;
            vid.VBlank <= 1'b0;
            vid.HSync  <= 1'b0;
            vid.VSync  <= 1'b0;
            vid.hcnt   <= '0;
            vid.vcnt   <= '0;
            vid.frame  <= 1'b0;
        end else begin
            vid.ce_pix <= step;
            if (step) begin
                div_q      <= '0;
                h_pos      <= h_nxt;
                v_pos      <= v_nxt;
                vid.hcnt   <= h_nxt;
                vid.vcnt   <= v_nxt;
                vid.HBlank <= (h_nxt >= H_ACTIVE_W);
                vid.VBlank <= (v_nxt >= V_ACTIVE_W);
                vid.HSync  <= hsync_nxt;
                vid.VSync  <= vsync_nxt;
                vid.frame  <= new_frame;
                if (new_frame) begin
                    hs_q <= vid.h_shift;
                    vs_q <= vid.v_shift;
                end
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_arcade_video_timing.sv
// Bench for arcade_video_timing: a small raster geometry built twice
// (CE_DIV=2 and CE_DIV=1) driven with random sync shifts, directed shift
// changes and a mid-frame reset. Expected pixels come from an arithmetic
// model of the raster (pixel index -> column/line) and are checked by
// per-instance monitors whenever ce_pix is high.
module tb_arcade_video_timing;

    localparam int HT  = 48;
    localparam int HA  = 24;
    localparam int HSS = 34;
    localparam int HSE = 38;
    localparam int VT  = 36;
    localparam int VA  = 16;
    localparam int VSS = 24;
    localparam int VSE = 27;
    localparam int HWT = 7;
    localparam int VWT = 7;
    localparam int CE0 = 2;
    localparam int CE1 = 1;
    localparam int W   = HWT + VWT + 5;
    localparam int FRAME_CLK0 = HT * VT * CE0;

    logic       clk;
    logic       reset;
    logic [3:0] h_shift_s;
    logic [3:0] v_shift_s;

    int tests = 0;
    int fails = 0;

    arcade_video_timing_if #(.HW(HWT), .VW(VWT)) vif0 ();
    arcade_video_timing_if #(.HW(HWT), .VW(VWT)) vif1 ();

    assign vif0.h_shift = h_shift_s;
    assign vif0.v_shift = v_shift_s;
    assign vif1.h_shift = h_shift_s;
    assign vif1.v_shift = v_shift_s;

    arcade_video_timing #(
        .CE_DIV(CE0), .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS), .HS_END(HSE),
        .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_END(VSE), .HW(HWT), .VW(VWT)
    ) dut0 (
        .clk_video(clk),
        .reset(reset),
        .vid(vif0)
    );

    arcade_video_timing #(
        .CE_DIV(CE1), .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS), .HS_END(HSE),
        .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_END(VSE), .HW(HWT), .VW(VWT)
    ) dut1 (
        .clk_video(clk),
        .reset(reset),
        .vid(vif1)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the raster as plain arithmetic on the pixel index.
    function automatic int sext4(input logic [3:0] x);
        return {{28{x[3]}}, x};
    endfunction

    function automatic logic [W-1:0] exp_pixel(input int n, input int hs, input int vs);
        int p;
        int h;
        int v;
        logic [HWT-1:0] hb;
        logic [VWT-1:0] vb;
        p  = n % (HT * VT);
        h  = p % HT;
        v  = p / HT;
        hb = HWT'(h);
        vb = VWT'(v);
        return {(p == 0), (h >= HSS + hs && h < HSE + hs), (v >= VSS + vs && v < VSE + vs),
                (h >= HA), (v >= VA), vb, hb};
    endfunction

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    bit exp_ce0 = 1'b0;
    bit exp_ce1 = 1'b0;

    // Model for the CE_DIV=2 build: pixel n is stepped on the (n+1)*CE0-th edge after release.
    initial begin
        int cyc;
        int n;
        int hs;
        int vs;
        cyc = 0; hs = 0; vs = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                cyc = 0;
                exp_ce0 = 1'b0;
            end else begin
                cyc++;
                exp_ce0 = (cyc % CE0 == 0);
                if (exp_ce0) begin
                    n = cyc / CE0 - 1;
                    if (n % (HT * VT) == 0) begin
                        hs = sext4(h_shift_s);
                        vs = sext4(v_shift_s);
                    end
                    exp_q0.push_back(exp_pixel(n, hs, vs));
                end
            end
        end
    end

    // Model for the CE_DIV=1 build.
    initial begin
        int cyc;
        int n;
        int hs;
        int vs;
        cyc = 0; hs = 0; vs = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                cyc = 0;
                exp_ce1 = 1'b0;
            end else begin
                cyc++;
                exp_ce1 = (cyc % CE1 == 0);
                if (exp_ce1) begin
                    n = cyc / CE1 - 1;
                    if (n % (HT * VT) == 0) begin
                        hs = sext4(h_shift_s);
                        vs = sext4(v_shift_s);
                    end
                    exp_q1.push_back(exp_pixel(n, hs, vs));
                end
            end
        end
    end

    // Monitor / scoreboard for the CE_DIV=2 build.
    initial begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        forever begin
            @(negedge clk);
            tests++;
            if (vif0.ce_pix !== exp_ce0) begin
                fails++;
                $display("FAIL ce_pix0 got=%b exp=%b t=%0t", vif0.ce_pix, exp_ce0, $time);
            end
            if (vif0.ce_pix === 1'b1) begin
                got = {vif0.frame, vif0.HSync, vif0.VSync, vif0.HBlank, vif0.VBlank, vif0.vcnt, vif0.hcnt};
                tests++;
                if (exp_q0.size() == 0) begin
                    fails++;
                    $display("FAIL pix0_unexpected got=%h exp=none t=%0t", got, $time);
                end else begin
                    exp = exp_q0.pop_front();
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL pix0 got h=%0d v=%0d f/hs/vs/hb/vb=%b exp h=%0d v=%0d f/hs/vs/hb/vb=%b t=%0t",
                                 got[HWT-1:0], got[HWT+VWT-1:HWT], got[W-1:HWT+VWT],
                                 exp[HWT-1:0], exp[HWT+VWT-1:HWT], exp[W-1:HWT+VWT], $time);
                    end
                end
                tests++;
                if ((vif0.HSync && !vif0.HBlank) || (vif0.VSync && !vif0.VBlank)) begin
                    fails++;
                    $display("FAIL sync_in_active0 got hs=%b hb=%b vs=%b vb=%b exp sync only in blank",
                             vif0.HSync, vif0.HBlank, vif0.VSync, vif0.VBlank);
                end
            end
        end
    end

    // Monitor / scoreboard for the CE_DIV=1 build.
    initial begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        forever begin
            @(negedge clk);
            tests++;
            if (vif1.ce_pix !== exp_ce1) begin
                fails++;
                $display("FAIL ce_pix1 got=%b exp=%b t=%0t", vif1.ce_pix, exp_ce1, $time);
            end
            if (vif1.ce_pix === 1'b1) begin
                got = {vif1.frame, vif1.HSync, vif1.VSync, vif1.HBlank, vif1.VBlank, vif1.vcnt, vif1.hcnt};
                tests++;
                if (exp_q1.size() == 0) begin
                    fails++;
                    $display("FAIL pix1_unexpected got=%h exp=none t=%0t", got, $time);
                end else begin
                    exp = exp_q1.pop_front();
                    if (got !== exp) begin
                        fails++;
                        $display("FAIL pix1 got h=%0d v=%0d f/hs/vs/hb/vb=%b exp h=%0d v=%0d f/hs/vs/hb/vb=%b t=%0t",
                                 got[HWT-1:0], got[HWT+VWT-1:HWT], got[W-1:HWT+VWT],
                                 exp[HWT-1:0], exp[HWT+VWT-1:HWT], exp[W-1:HWT+VWT], $time);
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic check_zero(input string nm);
        logic [W:0] g0;
        logic [W:0] g1;
        g0 = {vif0.ce_pix, vif0.frame, vif0.HSync, vif0.VSync, vif0.HBlank, vif0.VBlank, vif0.vcnt, vif0.hcnt};
        g1 = {vif1.ce_pix, vif1.frame, vif1.HSync, vif1.VSync, vif1.HBlank, vif1.VBlank, vif1.vcnt, vif1.hcnt};
        tests++;
        if (g0 !== '0 || g1 !== '0) begin
            fails++;
            $display("FAIL %s got dut0=%h dut1=%h exp all zero", nm, g0, g1);
        end
    endtask

    task automatic wait_pos(input int h, input int v, input string nm);
        bit found;
        found = 1'b0;
        for (int t = 0; t < 2 * FRAME_CLK0 && !found; t++) begin
            @(negedge clk);
            if (vif0.ce_pix === 1'b1 && vif0.hcnt == HWT'(h) && vif0.vcnt == VWT'(v)) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL %s timeout got no pixel (%0d,%0d) exp reached", nm, h, v);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    // Stimulus
    initial begin
        int elapsed;
        int k;
        reset     = 1'b1;
        h_shift_s = 4'd0;
        v_shift_s = 4'd0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        release_reset();

        // Two frames with no shift.
        repeat (2 * FRAME_CLK0) @(negedge clk);

        // Mid-frame shift -8/+7: current frame unaffected, next frame shifted.
        wait_pos(0, 5, "wait_shift_a");
        h_shift_s = 4'h8;
        v_shift_s = 4'h7;
        wait_pos(0, 5, "wait_shift_b");
        h_shift_s = 4'h7;
        wait_pos(0, 5, "wait_shift_c");

        // Random shift changes at random times.
        elapsed = 0;
        while (elapsed < 3 * FRAME_CLK0) begin
            k = $urandom_range(50, 600);
            repeat (k) @(negedge clk);
            elapsed += k;
            h_shift_s = 4'($urandom_range(0, 15));
            v_shift_s = 4'($urandom_range(0, 15));
        end

        // Mid-frame reset: outputs must drop without a clock edge.
        wait_pos(20, 10, "wait_reset_pos");
        #1 reset = 1'b1;
        #1 check_zero("async_reset");
        repeat (3) @(negedge clk);
        check_zero("reset_hold");
        #1 reset = 1'b0;
        repeat (FRAME_CLK0 + 40) @(negedge clk);

        // Drain: every expected pixel must have been presented.
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            fails++;
            $display("FAIL drain got leftover q0=%0d q1=%0d exp 0", exp_q0.size(), exp_q1.size());
        end

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arcade_video_timing.md
Name: arcade_video_timing

Overview:
- Raster timing generator for arcade cores. It produces the pixel enable, blanking, sync, beam position and frame strobe that feed the arcade video output stage (ce_pix/HBlank/VBlank/HSync/VSync inputs).
- It supports a runtime screen-position shift of the sync pulses. The shift is latched once per frame so the picture never tears mid-frame.

Parameters:
- CE_DIV, 4: clk_video cycles per pixel (1..16).
- H_TOTAL, 384: pixels per line.
- H_ACTIVE, 256: visible pixels per line.
- HS_START, 304: nominal hcnt of the HSync rising edge.
- HS_END, 336: nominal hcnt of the HSync falling edge (exclusive).
- V_TOTAL, 264: lines per frame.
- V_ACTIVE, 224: visible lines.
- VS_START, 240: nominal vcnt of the VSync rising edge.
- VS_END, 243: nominal vcnt of the VSync falling edge (exclusive).
- HW, 9: hcnt width.
- VW, 9: vcnt width.
- Legal parameter ranges:
  - H_ACTIVE+8 <= HS_START < HS_END <= H_TOTAL-8.
  - V_ACTIVE+8 <= VS_START < VS_END <= V_TOTAL-8.
  - Elaboration fails if either range is violated.

Ports:
- clk_video, in, 1: video clock.
- reset, in, 1: asynchronous, active-high reset.
- h_shift, in, 4: signed HSync offset in pixels (-8..+7).
- v_shift, in, 4: signed VSync offset in lines (-8..+7).
- ce_pix, out, 1: pixel enable; one clk_video cycle high every CE_DIV cycles.
- HBlank, out, 1: horizontal blank.
- VBlank, out, 1: vertical blank.
- HSync, out, 1: horizontal sync, active high.
- VSync, out, 1: vertical sync, active high.
- hcnt, out, HW: current pixel column.
- vcnt, out, VW: current line.
- frame, out, 1: high during the ce_pix cycle of pixel (0,0).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs are 0.
  - Divider is 0.
  - Internal position is (H_TOTAL-1, V_TOTAL-1).
  - Latched shifts are 0.
- Divider:
  - Counts 0..CE_DIV-1.
  - On the edge where divider == CE_DIV-1, it wraps to 0 and ce_pix <= 1. On every other edge ce_pix <= 0.
  - When CE_DIV=1, ce_pix is 1 on every cycle from the first edge after reset release onward.
- Pixel step: occurs on the same edge that sets ce_pix.
  - Internal h advances; it wraps H_TOTAL-1 -> 0.
  - On h wrap, internal v advances; it wraps V_TOTAL-1 -> 0.
  - All timing outputs are registered from the new position on this same edge. They are therefore valid and stable throughout the ce_pix-high cycle and hold until the next step.
  - The first ce_pix after reset presents (0,0) with frame=1.
- Outputs at a step (new position h,v):
  - hcnt=h, vcnt=v.
  - HBlank = (h >= H_ACTIVE).
  - VBlank = (v >= V_ACTIVE).
  - HSync = (h >= HS_START+hs) && (h < HS_END+hs).
  - VSync = (v >= VS_START+vs) && (v < VS_END+vs).
  - frame = (h==0 && v==0); it is cleared at the next step.
- Shift latch:
  - hs and vs are sign-extended h_shift/v_shift, captured only at the step to (0,0).
  - Changes to h_shift/v_shift at any other time have no effect until the next frame.
  - Arithmetic for the sync compares is done at HW+1 / VW+1 bits signed, with no wrap. The parameter constraints guarantee that no sync pulse crosses the line or frame boundary.
- Consistency rules:
  - HSync pulse width is always HS_END-HS_START pixels.
  - VSync width is always VS_END-VS_START lines.
  - HSync is never asserted while HBlank=0.
  - VSync is never asserted while VBlank=0.
- Reset mid-frame: all outputs drop to 0 asynchronously. After release, the sequence restarts exactly as from power-on.

Test Plan:
- Defaults, release reset, 2 frames:
  - ce_pix period is 4 clocks with duty 1/4.
  - First ce_pix shows hcnt=0, vcnt=0, frame=1, all blanks/syncs 0.
  - frame pulses recur every 384*264*4 = 405504 clocks.
- Defaults, one line:
  - HBlank rises at hcnt=256 and falls at hcnt=0.
  - HSync is high for hcnt 304..335 (32 pixels).
  - At every line wrap, vcnt increments while hcnt goes 383 -> 0.
- Defaults, one frame:
  - VBlank is high for vcnt 224..263.
  - VSync is high for vcnt 240..242, rising at hcnt=0 of line 240.
- h_shift=-8, v_shift=+7 applied mid-frame:
  - The current frame keeps HSync at 304..335.
  - The next frame (after frame=1) has HSync 296..327 and VSync 247..249.
  - Set h_shift=+7 next frame -> HSync 311..342.
- CE_DIV=1 build: ce_pix is constantly 1 after reset release, and hcnt increments every clock.
- Assert reset at hcnt=100, vcnt=50 for 3 clocks:
  - Outputs are 0 immediately, without waiting for a clock edge.
  - The first ce_pix after release shows (0,0) with frame=1.
